pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (FI/ID/EX/MEM/WB).
//  Drives the pause inputs of the four inter-stage registers and the PC.
//  Detects load-use hazards, holds the pipe during multi-cycle data-memory access
//  (req/ack handshake with timeout), and squashes the fetched instruction on a taken branch.
//  Keeps a saturating count of stall cycles for performance debug.
// PARAMETERS
//  TIMEOUT  16  max MEM_WAIT cycles before entering MEM_ERR (>=1)
//  CNT_W    16  width of stall_cnt
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  id_rs         in   5      rs field of instruction in ID
//  id_rt         in   5      rt field of instruction in ID
//  id_use_rs     in   1      ID instruction reads rs
//  id_use_rt     in   1      ID instruction reads rt
//  ex_is_load    in   1      instruction in EX is a load (writeback selects memrd)
//  ex_wa         in   5      destination register of instruction in EX
//  mem_req       in   1      MEM stage starts a data-memory access this cycle
//  mem_ack       in   1      data memory completes the access
//  branch_taken  in   1      branch/jump resolved taken in ID
//  pause_pc      out  1      hold PC
//  pause_fi_id   out  1      hold FI_ID
//  pause_id_ex   out  1      ID_EX: hold contents, outputs forced to 0 (bubble)
//  pause_ex_mem  out  1      hold EX_MEM
//  pause_mem_wb  out  1      hold MEM_WB
//  flush_fi_id   out  1      load zero (NOP) into FI_ID on next edge
//  mem_err       out  1      sticky: memory access timed out
//  stall_cnt     out  CNT_W  saturating count of cycles with pause_pc=1
// BEHAVIOUR
//  State reg (RUN, MEM_WAIT, MEM_ERR) and counters update on posedge clk; outputs are
//  combinational from state and inputs (zero-latency stall, same cycle as the condition).
//  Reset (rst=1, async): state=RUN, wait_cnt=0, stall_cnt=0, mem_err=0; all pause/flush
//  outputs 0 while rst=1. Reset mid-MEM_WAIT aborts the wait; no residual pause after release.
//  hazard = ex_is_load & (ex_wa!=0) & ((id_use_rs & id_rs==ex_wa) | (id_use_rt & id_rt==ex_wa)).
//  memstall = mem_req & ~mem_ack.
//  RUN:
//   - memstall: all five pauses=1, flush_fi_id=0; next state MEM_WAIT, wait_cnt<=1.
//   - else hazard: pause_pc=pause_fi_id=pause_id_ex=1, pause_ex_mem=pause_mem_wb=0
//     (one bubble enters EX); flush_fi_id=0; branch_taken ignored this cycle.
//   - else branch_taken: flush_fi_id=1, all pauses 0.
//   - else all outputs 0.
//   - mem_req & mem_ack same cycle: zero-wait access, no stall.
//  MEM_WAIT: all pauses=1, flush_fi_id=0.
//   - mem_ack=1: pauses still 1 this cycle, next state RUN, wait_cnt<=0.
//   - mem_ack=0 & wait_cnt==TIMEOUT: next state MEM_ERR, mem_err<=1.
//   - else wait_cnt<=wait_cnt+1. mem_req is don't-care in this state.
//  MEM_ERR: all pauses=1 permanently, flush_fi_id=0; exit only via rst.
//  Precedence: rst > memstall/MEM_WAIT > hazard > branch_taken.
//  stall_cnt increments each cycle pause_pc=1, holds at all-ones (no wrap).
//  ex_wa==0 never raises a hazard (r0 is constant).
// TESTING
//  1 lw $3 in EX (ex_is_load=1,ex_wa=3), ID add with id_rs=3,use_rs=1 -> 1 cycle
//    pause_pc/fi_id/id_ex=1, ex_mem/mem_wb=0; next cycle all 0; stall_cnt=1.
//  2 ex_is_load=1,ex_wa=0,id_rs=0,use_rs=1 -> no pause; id_use_rt=0,id_rt=ex_wa=5 -> no pause.
//  3 mem_req=1, mem_ack low 3 cycles then high -> all pauses=1 for 4 cycles, RUN after,
//    stall_cnt=4.
//  4 TIMEOUT=4, mem_req=1, mem_ack held 0 -> mem_err=1 after 5th stall cycle, pauses stay 1;
//    pulse rst -> all outputs 0, state RUN.
//  5 branch_taken=1 with hazard=1 -> flush_fi_id=0, hazard stall; next cycle branch_taken=1
//    alone -> flush_fi_id=1, no pauses.
//  6 rst asserted asynchronously mid-MEM_WAIT (between edges) -> outputs drop to 0
//    immediately; CNT_W=2 saturation: 5 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Stall/flush control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath side is the master, the hazard sequencer is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_is_load;
  logic [4:0]       ex_wa;
  logic             mem_req;
  logic             mem_ack;
  logic             branch_taken;
  logic             pause_pc;
  logic             pause_fi_id;
  logic             pause_id_ex;
  logic             pause_ex_mem;
  logic             pause_mem_wb;
  logic             flush_fi_id;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_is_load, ex_wa,
           mem_req, mem_ack, branch_taken,
    input  pause_pc, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb,
           flush_fi_id, mem_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_is_load, ex_wa,
           mem_req, mem_ack, branch_taken,
    output pause_pc, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb,
           flush_fi_id, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, data-memory
// wait with timeout, taken-branch squash, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MEM_ERR  = 2'd2;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic              hazard;
  logic              memstall;
  logic              stall_all;
  logic              stall_haz;
  logic              flush;

  always_comb begin
    hazard = bus.ex_is_load && (bus.ex_wa != 5'd0) &&
             ((bus.id_use_rs && (bus.id_rs == bus.ex_wa)) ||
              (bus.id_use_rt && (bus.id_rt == bus.ex_wa)));
    memstall  = bus.mem_req && !bus.mem_ack;
    stall_all = 1'b0;
    stall_haz = 1'b0;
    flush     = 1'b0;
    // Outputs are gated by rst so an asynchronous reset releases the pipe at once.
    if (!rst) begin
      case (state)
        RUN: begin
          if (memstall)              stall_all = 1'b1;
          else if (hazard)           stall_haz = 1'b1;
          else if (bus.branch_taken) flush     = 1'b1;
        end
        MEM_WAIT, MEM_ERR: stall_all = 1'b1;
        default:           stall_all = 1'b0;
      endcase
    end
  end

  assign bus.pause_pc     = stall_all | stall_haz;
  assign bus.pause_fi_id  = stall_all | stall_haz;
  assign bus.pause_id_ex  = stall_all | stall_haz;
  assign bus.pause_ex_mem = stall_all;
  assign bus.pause_mem_wb = stall_all;
  assign bus.flush_fi_id  = flush;
  assign bus.mem_err      = mem_err;
  assign bus.stall_cnt    = stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (bus.pause_pc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN: begin
          if (memstall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT_V) begin
            state   <= MEM_ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        MEM_ERR: state <= MEM_ERR;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: a TIMEOUT=4 main instance plus
// a CNT_W=2 instance sharing its inputs to exercise counter saturation.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) ifm ();
  pipe_hazard_ctrl_if #(.CNT_W(2))  ifs ();

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ifm));
  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(ifs));

  assign ifs.id_rs        = ifm.id_rs;
  assign ifs.id_rt        = ifm.id_rt;
  assign ifs.id_use_rs    = ifm.id_use_rs;
  assign ifs.id_use_rt    = ifm.id_use_rt;
  assign ifs.ex_is_load   = ifm.ex_is_load;
  assign ifs.ex_wa        = ifm.ex_wa;
  assign ifs.mem_req      = ifm.mem_req;
  assign ifs.mem_ack      = ifm.mem_ack;
  assign ifs.branch_taken = ifm.branch_taken;

  typedef struct {
    logic [5:0] o;
    logic       e;
    int         c;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                       input logic [5:0] ctl);
    ifm.id_rs        = rs;
    ifm.id_rt        = rt;
    ifm.ex_wa        = wa;
    ifm.id_use_rs    = ctl[5];
    ifm.id_use_rt    = ctl[4];
    ifm.ex_is_load   = ctl[3];
    ifm.mem_req      = ctl[2];
    ifm.mem_ack      = ctl[1];
    ifm.branch_taken = ctl[0];
  endtask

  task automatic expect_now(input logic [5:0] eo, input logic ee, input int ec, input string tag);
    exp_t e;
    logic [5:0] obs;
    int         sat;
    sb.push_back('{o: eo, e: ee, c: ec, tag: tag});
    e   = sb.pop_front();
    obs = {ifm.pause_pc, ifm.pause_fi_id, ifm.pause_id_ex,
           ifm.pause_ex_mem, ifm.pause_mem_wb, ifm.flush_fi_id};
    sat = (e.c > 3) ? 3 : e.c;
    checks++;
    assert (obs === e.o) passes++;
    else $error("FAIL %s outputs observed=%b expected=%b", e.tag, obs, e.o);
    checks++;
    assert (ifm.mem_err === e.e) passes++;
    else $error("FAIL %s mem_err observed=%b expected=%b", e.tag, ifm.mem_err, e.e);
    checks++;
    assert (ifm.stall_cnt === 16'(e.c)) passes++;
    else $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, ifm.stall_cnt, e.c);
    checks++;
    assert (ifs.stall_cnt === 2'(sat)) passes++;
    else $error("FAIL %s sat_cnt observed=%0d expected=%0d", e.tag, ifs.stall_cnt, sat);
  endtask

  // ctl = {id_use_rs, id_use_rt, ex_is_load, mem_req, mem_ack, branch_taken}
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                      input logic [5:0] ctl, input logic [5:0] eo, input logic ee,
                      input int ec, input string tag);
    @(posedge clk);
    #1 drive(rs, rt, wa, ctl);
    #1 expect_now(eo, ee, ec, tag);
  endtask

  task automatic release_rst();
    drive(5'd0, 5'd0, 5'd0, 6'b000000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    drive(5'd0, 5'd0, 5'd0, 6'b000000);
    step(5'd0, 5'd0, 5'd0, 6'b000100, 6'b000000, 1'b0, 0, "rst_hold");
    release_rst();

    step(5'd3, 5'd0, 5'd3, 6'b101000, 6'b111000, 1'b0, 0, "lu_rs");
    step(5'd0, 5'd0, 5'd0, 6'b000000, 6'b000000, 1'b0, 1, "lu_after");
    step(5'd0, 5'd0, 5'd0, 6'b101000, 6'b000000, 1'b0, 1, "r0_dst");
    step(5'd0, 5'd5, 5'd5, 6'b001000, 6'b000000, 1'b0, 1, "rt_unused");
    step(5'd0, 5'd5, 5'd5, 6'b011000, 6'b111000, 1'b0, 1, "lu_rt");
    step(5'd5, 5'd0, 5'd5, 6'b100000, 6'b000000, 1'b0, 2, "non_load");
    step(5'd7, 5'd0, 5'd7, 6'b101001, 6'b111000, 1'b0, 2, "br_hazard");
    step(5'd0, 5'd0, 5'd0, 6'b000001, 6'b000001, 1'b0, 3, "br_alone");
    step(5'd0, 5'd0, 5'd0, 6'b000110, 6'b000000, 1'b0, 3, "zero_wait");

    step(5'd0, 5'd0, 5'd0, 6'b000100, 6'b111110, 1'b0, 3, "mw_start");
    step(5'd7, 5'd0, 5'd7, 6'b101000, 6'b111110, 1'b0, 4, "mw_1");
    step(5'd0, 5'd0, 5'd0, 6'b000000, 6'b111110, 1'b0, 5, "mw_2");
    step(5'd0, 5'd0, 5'd0, 6'b000011, 6'b111110, 1'b0, 6, "mw_ack");
    step(5'd0, 5'd0, 5'd0, 6'b000000, 6'b000000, 1'b0, 7, "mw_done");

    step(5'd0, 5'd0, 5'd0, 6'b000100, 6'b111110, 1'b0, 7, "edge_start");
    for (int i = 0; i < 3; i++)
      step(5'd0, 5'd0, 5'd0, 6'b000000, 6'b111110, 1'b0, 8 + i, "edge_wait");
    step(5'd0, 5'd0, 5'd0, 6'b000010, 6'b111110, 1'b0, 11, "edge_ack");
    step(5'd0, 5'd0, 5'd0, 6'b000000, 6'b000000, 1'b0, 12, "edge_done");

    step(5'd0, 5'd0, 5'd0, 6'b000100, 6'b111110, 1'b0, 12, "to_start");
    for (int i = 0; i < 4; i++)
      step(5'd0, 5'd0, 5'd0, 6'b000100, 6'b111110, 1'b0, 13 + i, "to_wait");
    step(5'd0, 5'd0, 5'd0, 6'b000100, 6'b111110, 1'b1, 17, "err_hold");
    step(5'd0, 5'd0, 5'd0, 6'b000010, 6'b111110, 1'b1, 18, "err_ack");

    #1 rst = 1'b1;
    #1 expect_now(6'b000000, 1'b0, 0, "err_rst");
    release_rst();
    step(5'd3, 5'd0, 5'd3, 6'b101000, 6'b111000, 1'b0, 0, "post_rst");

    step(5'd0, 5'd0, 5'd0, 6'b000100, 6'b111110, 1'b0, 1, "mid_start");
    step(5'd0, 5'd0, 5'd0, 6'b000100, 6'b111110, 1'b0, 2, "mid_wait");
    #1 rst = 1'b1;
    #1 expect_now(6'b000000, 1'b0, 0, "mid_rst");
    release_rst();
    step(5'd0, 5'd0, 5'd0, 6'b000000, 6'b000000, 1'b0, 0, "mid_after");

    for (int i = 0; i < 5; i++)
      step(5'd3, 5'd0, 5'd3, 6'b101000, 6'b111000, 1'b0, i, "sat_haz");
    step(5'd0, 5'd0, 5'd0, 6'b000000, 6'b000000, 1'b0, 5, "sat_done");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
